// File: rtl/pulse_player_pkg.sv
// Shared types, default parameters and helpers for the pulse_player serializer.
package pulse_player_pkg;

    localparam int unsigned DEF_PULSE_LENGTH = 32;
    localparam int unsigned DEF_DIV_W        = 16;
    localparam int unsigned DEF_REP_W        = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Limit a requested last-bit index to the last bit the pattern holds.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pulse_player_if.sv
// Control/status bundle between the transmit FSM and pulse_player.
interface pulse_player_if #(
    parameter int unsigned PULSE_LENGTH = 32,
    parameter int unsigned IDX_W        = $clog2(PULSE_LENGTH),
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned REP_W        = 8
);
    logic                    start;
    logic                    abort;
    logic [PULSE_LENGTH-1:0] pattern;
    logic [IDX_W-1:0]        length;
    logic [DIV_W-1:0]        bit_period;
    logic [REP_W-1:0]        repeats;
    logic                    out;
    logic                    busy;
    logic                    done;
    logic [IDX_W-1:0]        bit_idx;

    modport master (
        output start, abort, pattern, length, bit_period, repeats,
        input  out, busy, done, bit_idx
    );

    modport slave (
        input  start, abort, pattern, length, bit_period, repeats,
        output out, busy, done, bit_idx
    );
endinterface

// File: rtl/pulse_bit_select.sv
// Picks the pattern bit that will appear on the serial output next cycle.
module pulse_bit_select #(
    parameter int unsigned PULSE_LENGTH = 32,
    parameter int unsigned IDX_W        = $clog2(PULSE_LENGTH)
) (
    input  logic [PULSE_LENGTH-1:0] pattern,
    input  logic [IDX_W-1:0]        idx,
    output logic                    sel_c
);
    assign sel_c = pattern[idx];
endmodule

// File: rtl/pulse_player.sv
// Pattern serializer: plays bits 0..L of a latched pattern, P cycles per bit, R passes.
module pulse_player
    import pulse_player_pkg::*;
#(
    parameter int unsigned PULSE_LENGTH = DEF_PULSE_LENGTH,
    parameter int unsigned IDX_W        = $clog2(PULSE_LENGTH),
    parameter int unsigned DIV_W        = DEF_DIV_W,
    parameter int unsigned REP_W        = DEF_REP_W
) (
    input  logic          clk,
    input  logic          rst_n,
    pulse_player_if.slave bus
);

    state_t                  state_q, state_d;
    logic [PULSE_LENGTH-1:0] pat_q, pat_d;
    logic [IDX_W-1:0]        len_q, len_d;
    logic [DIV_W-1:0]        per_q, per_d;
    logic [REP_W-1:0]        rep_q, rep_d;
    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [REP_W-1:0]        pass_q, pass_d;
    logic                    out_q, out_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    sel_c;
    logic [REP_W-1:0]        pass_inc_c;

    assign pass_inc_c = REP_W'(pass_q + 1'b1);

    // Mux is fed next-cycle pattern/index so out is registered with no extra latency.
    pulse_bit_select #(
        .PULSE_LENGTH(PULSE_LENGTH),
        .IDX_W       (IDX_W)
    ) u_bit_select (
        .pattern(pat_d),
        .idx    (idx_d),
        .sel_c  (sel_c)
    );

    assign out_d = (state_d == PLAY) & sel_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            per_q   <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            per_q   <= per_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        per_d   = per_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pass_d  = pass_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = PLAY;
                    pat_d   = bus.pattern;
                    len_d   = IDX_W'(clamp_len(32'(bus.length), 32'(PULSE_LENGTH - 1)));
                    // A zero period is stored as one so the wrap test is a plain compare.
                    per_d   = (bus.bit_period == '0) ? DIV_W'(1) : bus.bit_period;
                    rep_d   = bus.repeats;
                    cnt_d   = '0;
                    idx_d   = '0;
                    pass_d  = '0;
                end
            end
            PLAY: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == DIV_W'(per_q - 1'b1)) begin
                    cnt_d = '0;
                    if (idx_q == len_q) begin
                        idx_d = '0;
                        // Looping runs (R=0) leave the pass counter untouched.
                        if (rep_q != '0) begin
                            pass_d = pass_inc_c;
                            if (pass_inc_c == rep_q) begin
                                state_d = FINISH;
                            end
                        end
                    end else begin
                        idx_d = IDX_W'(idx_q + 1'b1);
                    end
                end else begin
                    cnt_d = DIV_W'(cnt_q + 1'b1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == PLAY);
        done_d = (state_d == FINISH);
    end

    assign bus.out     = out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bit_idx = idx_q;

endmodule

// File: doc/pulse_player.md
# pulse_player

Parametrised pulse-pattern serializer for the transmit path. It latches a PULSE_LENGTH-bit pattern and plays it out LSB-first, one bit per programmable bit period. It supports a programmable played length, repeat count or continuous looping, and abort. The transmit FSM drives its start/done handshake, and its serial output feeds the transmitter drive.

## Interface
- PULSE_LENGTH, 32, pattern width in bits; minimum 2.
- IDX_W, $clog2(PULSE_LENGTH), width of bit index and length field.
- DIV_W, 16, width of the bit-period field.
- REP_W, 8, width of the repeat-count field.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin playback; sampled only in IDLE.
- abort  input  1  terminate playback; no done is issued.
- pattern  input  PULSE_LENGTH  bits to play; bit 0 is played first.
- length  input  IDX_W  index of the last bit played (L); plays bits 0..L.
- bit_period  input  DIV_W  cycles each bit is held (P); a value of 0 is treated as 1.
- repeats  input  REP_W  number of passes (R); 0 means loop until abort.
- out  output  1  registered serial pulse output.
- busy  output  1  high while in PLAY.
- done  output  1  one-cycle pulse after normal completion.
- bit_idx  output  IDX_W  index of the bit currently on out.

## Operation
- States:
  - IDLE: out=0, busy=0.
  - PLAY: out=pattern_q[bit_idx], busy=1.
  - FINISH: one cycle; out=0, busy=0, done=1.
- IDLE→PLAY: on start=1 with abort=0.
  - Latches pattern, length (clamped to PULSE_LENGTH-1), bit_period and repeats into shadow registers.
  - Clears bit_idx, the period counter and the pass counter.
- Inputs other than start and abort are ignored outside IDLE; shadow registers hold for the whole run.
- PLAY: the period counter counts 0..P-1. At P-1 the counter wraps and bit_idx advances.
  - When bit_idx==L and the counter is at P-1, the pass ends.
  - After the pass ends, bit_idx returns to 0 and the pass counter increments.
  - When the pass counter reaches R (R≠0), the next state is FINISH. Otherwise the next pass starts seamlessly, with no gap bit.
- R=0: loop indefinitely; the pass counter does not saturate or overflow the exit test.
- FINISH→IDLE unconditionally. A start asserted in FINISH is ignored.
- abort in PLAY: the next state is IDLE; out, busy and done are all 0. abort takes priority over pass completion in the same cycle.
- abort and start together in IDLE: abort wins, so no start occurs.
- start held high: only one run per IDLE visit; the next start is accepted on the first IDLE cycle.

## Timing
- Reset values: state=IDLE, out=0, busy=0, done=0, bit_idx=0, all counters and shadow registers 0.
- Reset mid-run returns to IDLE immediately (asynchronously) and produces no done.
- Start sampled at edge k: out=pattern[0] and busy=1 from k+1. out is registered, with zero extra pipeline delay.
- Each bit is held for exactly P cycles. PLAY lasts (L+1)·P·R cycles.
- done is high for the single cycle after the last PLAY cycle. The earliest next start is accepted one cycle after done.
- Minimum start-to-start spacing is (L+1)·P·R+2 cycles.

## Structure
- Shared package pulse_player_pkg holds:
  - the state enum (IDLE, PLAY, FINISH);
  - the default parameter constants;
  - a clamp function for length.
- One sub-module, pulse_bit_select: combinational, parametrised PULSE_LENGTH-to-1 mux from pattern_q and bit_idx to the next out bit.
- Counters (period, bit index, pass) and the FSM live in the top level.

## Test plan
- Single pass, pattern=0xA5, L=7, P=1, R=1, start at cycle 0 → out=1,0,1,0,0,1,0,1 on cycles 1–8; done=1 at cycle 9 only; busy high on cycles 1–8.
- Bit period and repeats, pattern=0x3, L=1, P=3, R=2 → out high for 6 cycles in each pass, 12 cycles total; done once at cycle 13.
- Clamp and P=0, L=31 with PULSE_LENGTH=8, P=0 → L treated as 7 and P treated as 1; exactly 8 output cycles, then done.
- Loop and abort, pattern=0x1, L=3, P=2, R=0 → out=1,1,0,0,0,0,0,0 repeating; abort at cycle 20 → IDLE at cycle 21 with out=0 and no done.
- Collision and ignore:
  - start with abort in IDLE → no run.
  - start asserted during PLAY or FINISH → ignored, and shadow values are unchanged.
- Async reset: rst_n low mid-PLAY → out, busy, done and bit_idx go to 0 immediately; the first start after release runs normally.
